// File: rtl/peridot_uart_pkg.sv
// peridot_uart_pkg
// Shared constants for the UART transmit path. The byte width and the
// default transmit FIFO depth live here so the PHY stages and the FIFO
// agree on them without repeating literals.
package peridot_uart_pkg;

  localparam int BYTE_W                  = 8;
  localparam int FIFO_DEPTH_LOG2_DEFAULT = 4;

  // Number of FIFO entries for a given log2 depth.
  function automatic int fifoDepth(input int depthLog2);
    return 1 << depthLog2;
  endfunction

endpackage

// File: rtl/peridot_txd_fifo_mem.sv
// peridot_txd_fifo_mem
// Byte storage for the transmit FIFO: DEPTH x BYTE_W array with one
// synchronous write port and one asynchronous read port. Contents are not
// reset; the FIFO control logic never exposes an entry it has not written.
//
// Ports:
//   clock_sig  - rising-edge clock
//   wrEn_i     - write strobe
//   wrAddr_i   - write address
//   wrData_i   - write byte
//   rdAddr_i   - read address
//   rdData_o   - byte at rdAddr_i (combinational)
module peridot_txd_fifo_mem
  import peridot_uart_pkg::*;
#(
  parameter int ADDR_W = FIFO_DEPTH_LOG2_DEFAULT
) (
  input  logic              clock_sig,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [BYTE_W-1:0] wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [BYTE_W-1:0] rdData_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [BYTE_W-1:0] memArray_q [DEPTH];

  always_ff @(posedge clock_sig) begin
    if (wrEn_i) begin
      memArray_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = memArray_q[rdAddr_i];

endmodule

// File: rtl/peridot_txd_fifo.sv
// peridot_txd_fifo
// Byte buffer in front of the UART sender PHY. Absorbs host bursts and
// drains one byte per downstream ready/valid handshake.
//
// Ports:
//   clock_sig  - rising-edge clock
//   reset_sig  - asynchronous, active-high reset (empties the FIFO)
//   flush      - synchronous clear; wins over a same-cycle write or read
//   in_ready   - FIFO can accept a byte (level < DEPTH)
//   in_valid   - upstream presents in_data
//   in_data    - upstream byte
//   out_ready  - downstream accepts out_data
//   out_valid  - FIFO holds at least one byte
//   out_data   - oldest stored byte
//   level      - number of stored bytes, 0..DEPTH
module peridot_txd_fifo
  import peridot_uart_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEFAULT
) (
  input  logic                     clock_sig,
  input  logic                     reset_sig,
  input  logic                     flush,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [BYTE_W-1:0]        out_data,
  output logic [FIFO_DEPTH_LOG2:0] level
);

  localparam int                     DEPTH      = fifoDepth(FIFO_DEPTH_LOG2);
  localparam logic [FIFO_DEPTH_LOG2:0]   LEVEL_FULL = DEPTH[FIFO_DEPTH_LOG2:0];
  localparam logic [FIFO_DEPTH_LOG2:0]   LEVEL_ONE  = 1;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = 1;

  logic [FIFO_DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;
  logic                       doWrite;
  logic                       doRead;

  // Flags come from the level register only, so in_ready never depends
  // combinationally on out_ready: a full FIFO refuses a write even when a
  // read frees a slot in the same cycle.
  assign in_ready  = (level_q != LEVEL_FULL);
  assign out_valid = (level_q != '0);
  assign level     = level_q;

  assign doWrite = in_valid  & in_ready  & ~flush;
  assign doRead  = out_valid & out_ready & ~flush;

  // Pointers wrap naturally at DEPTH because they are exactly log2 wide.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (doWrite) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (doRead) begin
        rdPtr_d = rdPtr_q + PTR_ONE;
      end
      case ({doWrite, doRead})
        2'b10:   level_d = level_q + LEVEL_ONE;
        2'b01:   level_d = level_q - LEVEL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  peridot_txd_fifo_mem #(
    .ADDR_W (FIFO_DEPTH_LOG2)
  ) u_mem (
    .clock_sig (clock_sig),
    .wrEn_i    (doWrite),
    .wrAddr_i  (wrPtr_q),
    .wrData_i  (in_data),
    .rdAddr_i  (rdPtr_q),
    .rdData_o  (out_data)
  );

endmodule

// File: tb/tb_peridot_txd_fifo.sv
// tb_peridot_txd_fifo
// Self-checking bench for peridot_txd_fifo with the default depth of 16.
// A queue of accepted bytes stands in for the FIFO: writes push, reads pop,
// flush and reset clear it. Outputs are compared on the falling edge.
module tb_peridot_txd_fifo;

  localparam int DEPTH = 16;

  logic       clock_sig = 1'b0;
  logic       reset_sig = 1'b1;
  logic       flush     = 1'b0;
  logic       in_ready;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [4:0] level;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int maxLevel   = 0;

  logic [7:0] modelQ [$];
  logic       lastWrite;

  peridot_txd_fifo dut (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .flush     (flush),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level)
  );

  always #5 clock_sig = ~clock_sig;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every visible output against the queue model.
  task automatic checkState(input string tag);
    checkOutput({tag, ".level"}, 32'(level), 32'(modelQ.size()));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(modelQ.size() != 0));
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(modelQ.size() < DEPTH));
    if (modelQ.size() != 0) begin
      checkOutput({tag, ".out_data"}, 32'(out_data), 32'(modelQ[0]));
    end
  endtask

  // One clock cycle: drive on the falling edge, check, then advance the
  // model on the rising edge using the pre-edge occupancy.
  task automatic applyStimulus(input string tag, input logic inV,
                               input logic [7:0] inD, input logic outR,
                               input logic fl);
    logic wr;
    logic rd;
    in_valid  = inV;
    in_data   = inD;
    out_ready = outR;
    flush     = fl;
    checkState(tag);
    wr = inV && (modelQ.size() < DEPTH) && !fl;
    rd = outR && (modelQ.size() != 0) && !fl;
    @(posedge clock_sig);
    if (fl) begin
      modelQ.delete();
    end else begin
      if (rd) void'(modelQ.pop_front());
      if (wr) modelQ.push_back(inD);
    end
    if (modelQ.size() > maxLevel) maxLevel = modelQ.size();
    lastWrite = wr;
    @(negedge clock_sig);
  endtask

  initial begin
    // Reset-then-idle.
    #2;
    checkState("reset");
    @(negedge clock_sig);
    reset_sig = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill with 0x00..0x0F, then offer 0xAA while full.
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("full.level", 32'(level), 32'd16);
    checkOutput("full.in_ready", 32'(in_ready), 32'd0);
    applyStimulus("full.offerAA", 1'b1, 8'hAA, 1'b0, 1'b0);

    // Write and read together while full: only the read happens.
    applyStimulus("full.rw", 1'b1, 8'hBB, 1'b1, 1'b0);
    checkOutput("fullrw.level", 32'(level), 32'd15);
    checkOutput("fullrw.out_data", 32'(out_data), 32'h01);

    // Drain the rest.
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("drained.level", 32'(level), 32'd0);

    // Wrap-around stream 0x30..0x57 with out_ready toggling.
    begin
      int idx = 0;
      int cyc = 0;
      while ((idx < 40 || modelQ.size() != 0) && cyc < 400) begin
        applyStimulus("wrap", idx < 40, 8'(8'h30 + idx), cyc[0], 1'b0);
        if (lastWrite) idx++;
        cyc++;
      end
      checkOutput("wrap.allSent", 32'(idx), 32'd40);
      checkOutput("wrap.maxLevel", 32'(maxLevel <= DEPTH), 32'd1);
    end

    // Flush precedence with level 5 and 0x77 offered.
    for (int i = 0; i < 5; i++) applyStimulus("preflush", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("flush.level", 32'(level), 32'd0);
    checkOutput("flush.out_valid", 32'(out_valid), 32'd0);
    applyStimulus("postflush.wr", 1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("postflush.out_data", 32'(out_data), 32'h11);
    applyStimulus("postflush.rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Mid-stream asynchronous reset with level 7.
    for (int i = 0; i < 7; i++) applyStimulus("prereset", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    checkOutput("prereset.level", 32'(level), 32'd7);
    in_valid = 1'b0;
    #1 reset_sig = 1'b1;
    #1;
    modelQ.delete();
    checkOutput("midreset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset.level", 32'(level), 32'd0);
    checkOutput("midreset.in_ready", 32'(in_ready), 32'd1);
    #1 reset_sig = 1'b0;
    @(negedge clock_sig);
    applyStimulus("postreset.wr", 1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("postreset.out_data", 32'(out_data), 32'h5A);
    applyStimulus("postreset.rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
    end
    checkState("final");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
